// File: rtl/aukv_uart_tx_arbiter.sv
// aukv_uart_tx_arbiter: round-robin share of one UART TX pin between two byte requesters, 8N1 framing.
// Latency: handshake at edge k drives the start bit from edge k+1; frame is 10*CLK_DIV cycles (11*CLK_DIV with parity).
// Backpressure: ready only in IDLE for the granted requester; at least one IDLE cycle separates frames.
// Optional feature: define AUKV_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module aukv_uart_tx_arbiter #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  output logic       o_req1_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_last_grant
);

  // Baud counter wide enough to hold CLK_DIV-1
  localparam int unsigned       CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef AUKV_UART_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             busy_q;
  logic             last_grant_q;
`ifdef AUKV_UART_PARITY_EN
  logic             parity_q;
`endif

  logic             idle;
  logic             grant_d;
  logic             req0_rdy;
  logic             req1_rdy;
  logic             accept;
  logic [7:0]       acc_data;
  logic             baud_last;

  // Round-robin grant: a lone requester always wins; on contention the one not served last wins
  always_comb begin
    grant_d = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant_d = ~last_grant_q;
    end else if (i_req1_valid) begin
      grant_d = 1'b1;
    end
    idle      = (state_q == ST_IDLE);
    req0_rdy  = idle & ~grant_d & i_req0_valid;
    req1_rdy  = idle &  grant_d & i_req1_valid;
    accept    = req0_rdy | req1_rdy;
    acc_data  = grant_d ? i_req1_data : i_req0_data;
    baud_last = (baud_q == CNT_LAST);
  end

  // Frame FSM: every output-facing bit (tx, busy, last grant) is registered here
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef AUKV_UART_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (accept) begin
            shift_q      <= acc_data;
`ifdef AUKV_UART_PARITY_EN
            // Parity taken at accept time since the shift register is consumed bit by bit
            parity_q     <= ^acc_data;
`endif
            last_grant_q <= grant_d;
            bit_idx_q    <= '0;
            baud_q       <= '0;
            state_q      <= ST_START;
            tx_q         <= 1'b0;
            busy_q       <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef AUKV_UART_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

`ifdef AUKV_UART_PARITY_EN
        ST_PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end
`endif

        ST_STOP: begin
          if (baud_last) begin
            // Return to IDLE for at least one cycle before the next accept
            baud_q  <= '0;
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            baud_q <= baud_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_req0_ready = req0_rdy;
  assign o_req1_ready = req1_rdy;
  assign o_tx         = tx_q;
  assign o_busy       = busy_q;
  assign o_last_grant = last_grant_q;

endmodule

// File: tb/tb_aukv_uart_tx_arbiter.sv
// tb_aukv_uart_tx_arbiter: directed scenarios plus random traffic against a frame-level reference model.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// The model expresses each frame as a bit list held DIV cycles per bit, with arbitration by rule.
`timescale 1ns/1ps
module tb_aukv_uart_tx_arbiter;

  localparam int DIV = 4;
`ifdef AUKV_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * DIV;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       v0   = 1'b0;
  logic       v1   = 1'b0;
  logic [7:0] d0   = 8'h00;
  logic [7:0] d1   = 8'h00;
  logic       rdy0, rdy1, tx, busy, last_grant;

  aukv_uart_tx_arbiter #(.CLK_DIV(DIV)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_req0_valid (v0),
    .i_req0_data  (d0),
    .o_req0_ready (rdy0),
    .i_req1_valid (v1),
    .i_req1_data  (d1),
    .o_req1_ready (rdy1),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_last_grant (last_grant)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: active frame, position inside it, last accepted requester
  bit m_act   = 1'b0;
  int m_pos   = 0;
  bit m_last  = 1'b1;
  bit m_frame [NBITS];
  int m_frames = 0;
  int dut_acc0 = 0;
  int dut_acc1 = 0;

  function automatic void load_frame(input logic [7:0] b);
    m_frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_frame[i+1] = b[i];
`ifdef AUKV_UART_PARITY_EN
    m_frame[9] = ^b;
`endif
    m_frame[NBITS-1] = 1'b1;
  endfunction

  // Compare every output each cycle, then advance the model across the coming rising edge
  always @(negedge clk) begin
    bit g;
    bit e_tx;
    if (!rstn) begin
      m_act  = 1'b0;
      m_pos  = 0;
      m_last = 1'b1;
    end
    e_tx = m_act ? m_frame[m_pos / DIV] : 1'b1;
    chk_eq("tx", tx, e_tx);
    chk_eq("busy", busy, m_act);
    chk_eq("last_grant", last_grant, m_last);
    g = (v0 && v1) ? ~m_last : v1;
    if (rstn) begin
      chk_eq("ready0", rdy0, !m_act && v0 && !g);
      chk_eq("ready1", rdy1, !m_act && v1 && g);
      if (rdy0) dut_acc0++;
      if (rdy1) dut_acc1++;
      if (m_act) begin
        m_pos++;
        if (m_pos == FLEN) m_act = 1'b0;
      end else if (v0 || v1) begin
        load_frame(g ? d1 : d0);
        m_last = g;
        m_act  = 1'b1;
        m_pos  = 0;
        m_frames++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  initial begin
    int a0, a1;
    tick(3);
    chk_eq("rst_tx", tx, 1'b1);
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_last_grant", last_grant, 1'b1);
    chk_eq("rst_ready0", rdy0, 1'b0);
    chk_eq("rst_ready1", rdy1, 1'b0);
    rstn = 1'b1;
    tick(2);

    // Single byte from requester 0
    d0 = 8'h55; v0 = 1'b1;
    tick(1);
    v0 = 1'b0;
    tick(FLEN + 5);

    // Continuous contention after reset: four frames, alternating 0,1,0,1
    pulse_reset();
    a0 = dut_acc0; a1 = dut_acc1;
    d0 = 8'hA0; d1 = 8'h0B; v0 = 1'b1; v1 = 1'b1;
    tick(3 * (FLEN + 1) + 1);
    v0 = 1'b0; v1 = 1'b0;
    tick(FLEN + 5);
    chk_eq("alt_acc0", dut_acc0 - a0, 2);
    chk_eq("alt_acc1", dut_acc1 - a1, 2);

    // Lone requester 1 right after reset
    pulse_reset();
    a1 = dut_acc1;
    d1 = 8'hFF; v1 = 1'b1;
    tick(1);
    v1 = 1'b0;
    tick(FLEN + 5);
    chk_eq("lone_req1_acc", dut_acc1 - a1, 1);

    // Input churn while a frame is in flight must not disturb it
    d0 = 8'h12; v0 = 1'b1;
    tick(1);
    for (int i = 0; i < FLEN - 2; i++) begin
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      v1 = 1'($urandom);
      tick(1);
    end
    v0 = 1'b0; v1 = 1'b0;
    tick(2 * FLEN + 5);

    // Reset during data bit 3, then the pending 0x3C goes out whole
    d0 = 8'hC3; v0 = 1'b1;
    tick(1);
    d0 = 8'h3C;
    tick(17);
    rstn = 1'b0;
    #1;
    chk_eq("midrst_tx", tx, 1'b1);
    chk_eq("midrst_busy", busy, 1'b0);
    tick(2);
    rstn = 1'b1;
    tick(1);
    v0 = 1'b0;
    tick(FLEN + 5);

    // Parity-sensitive bytes
    d0 = 8'h07; v0 = 1'b1;
    tick(1);
    v0 = 1'b0;
    tick(FLEN + 3);
    d0 = 8'h03; v0 = 1'b1;
    tick(1);
    v0 = 1'b0;
    tick(FLEN + 3);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      tick(1);
    end
    v0 = 1'b0; v1 = 1'b0;
    tick(FLEN + 5);
    chk_eq("total_accepts", dut_acc0 + dut_acc1, m_frames);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aukv_uart_tx_arbiter.md
# aukv_uart_tx_arbiter

Shares the SoC's single UART transmit line between two byte-stream requesters (requester 0: CPU UART register path, requester 1: debug/status source) using round-robin arbitration. Accepts one byte at a time over a valid/ready handshake, serializes it as an 8N1 frame (optional parity), and drives the `o_tx` pin. Sits between the peripheral bus slaves and the top-level `o_tx` port of `aukv_eggs_soc`.

## Interface
- `CLK_DIV`, 434, clock cycles per bit (50 MHz / 115200); legal range 2..65535
- `i_clk`  in  1  system clock
- `i_rstn`  in  1  asynchronous active-low reset
- `i_req0_valid`  in  1  requester 0 has a byte
- `i_req0_data`  in  8  requester 0 byte
- `o_req0_ready`  out  1  requester 0 byte accepted this cycle
- `i_req1_valid`  in  1  requester 1 has a byte
- `i_req1_data`  in  8  requester 1 byte
- `o_req1_ready`  out  1  requester 1 byte accepted this cycle
- `o_tx`  out  1  serial output, idle high
- `o_busy`  out  1  frame in progress (state != IDLE)
- `o_last_grant`  out  1  index of requester most recently accepted

## Operation
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: `o_tx`=1. Grant computed combinationally: if only one valid, grant it; if both valid, grant the requester != `o_last_grant`. `o_reqN_ready` = IDLE & grant==N & `i_reqN_valid`; at most one ready high per cycle.
- Handshake (valid & ready): latch data into shift register, update `o_last_grant`, clear bit counter and baud counter, go START.
- START: `o_tx`=0 for CLK_DIV cycles, then DATA.
- DATA: 8 bits LSB first, each CLK_DIV cycles; 3-bit index counts 0..7; after bit 7 -> PARITY or STOP.
- STOP: `o_tx`=1 for CLK_DIV cycles, then IDLE.
- Baud counter: width clog2(CLK_DIV); counts 0..CLK_DIV-1, wraps to 0 at state change.
- Ready never asserted outside IDLE; valid/data changes while busy are ignored. Requester may drop valid before acceptance with no effect.
- No starvation: with both valid continuously, grants strictly alternate 0,1,0,1...

## Timing
- Reset values: `o_tx`=1, `o_busy`=0, `o_req0_ready`=`o_req1_ready`=0 (state IDLE, no valid), `o_last_grant`=1 (so requester 0 wins first contention), state IDLE, counters 0.
- `o_tx` and `o_busy` registered. Handshake at edge k -> `o_tx`=0 and `o_busy`=1 from edge k+1.
- Frame length 10*CLK_DIV cycles (11*CLK_DIV with parity). Back-to-back: state returns to IDLE for at least 1 cycle, so frame-start period is 10*CLK_DIV+1 cycles.
- Reset asserted mid-frame: `o_tx` forced to 1 and `o_busy` to 0 asynchronously; partial frame discarded; no ready pulse until reset released and a valid seen in IDLE.

## Configuration
- `AUKV_UART_PARITY_EN` defined: PARITY state inserted after DATA, drives even parity (XOR of 8 data bits) for CLK_DIV cycles; frame 11*CLK_DIV.
- Not defined: no PARITY state; DATA goes directly to STOP; 8N1 frame of 10*CLK_DIV.

## Test plan
- Reset then `i_req0_valid`=1, data 0x55, CLK_DIV=4 -> `o_req0_ready` one cycle, `o_tx` sequence 0,1,0,1,0,1,0,1,0,1 each held 4 cycles, `o_busy` high 40 cycles.
- Both valid continuously, req0=0xA0, req1=0x0B, 4 frames -> accept order 0,1,0,1; decoded bytes A0,0B,A0,0B; `o_last_grant` toggles.
- Only req1 valid with 0xFF after reset -> granted despite `o_last_grant`=1 reset value; frame 0 then eight 1s then 1.
- Change `i_req0_data` and raise `i_req1_valid` mid-frame -> serialized byte unchanged, no ready pulse until IDLE.
- Assert `i_rstn`=0 during bit 3 of a frame -> `o_tx`=1, `o_busy`=0 immediately; after release, pending req0 0x3C sent complete and correct.
- With `AUKV_UART_PARITY_EN`, byte 0x07 -> parity bit 1, frame 11*CLK_DIV cycles; byte 0x03 -> parity bit 0.
